// File: rtl/nios_fast_ocimem_arbiter.sv
// Debug-RAM controller: executes JTAG OCI-memory commands and shares the single-port RAM with the CPU debug slave.
// Optional feature: define OCIMEM_AUTOINC_EN to post-increment the JTAG address after every completed read/write.
module nios_fast_ocimem_arbiter #(
  parameter int ADDR_W      = 8,
  parameter bit START_GRANT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [2:0] {IDLE, CPU_WR, CPU_RD, CPU_RDW, J_WR, J_RD, J_RDW} state_t;

  state_t            state;
  logic [ADDR_W-1:0] jtag_addr;
  logic [ADDR_W-1:0] next_jtag_addr;
  logic              pend;
  logic              pend_wr;
  logic [31:0]       pend_wdata;
  logic              last_grant;
  logic              cpu_req;
  logic              jtag_busy;
  logic              tie;
  logic              grant_jtag;
  logic              grant_cpu;
  logic              unused_jdo;

  // last_grant = 1 means JTAG won the previous tie, so the CPU wins the next one.
  assign cpu_req        = av_read | av_write;
  assign jtag_busy      = pend | (state == J_WR) | (state == J_RD) | (state == J_RDW);
  assign tie            = pend & cpu_req;
  assign grant_jtag     = pend & (~cpu_req | ~last_grant);
  assign grant_cpu      = cpu_req & ~grant_jtag;
  assign av_waitrequest = cpu_req & ~((state == CPU_WR) | (state == CPU_RDW));
  assign av_readdata    = (state == CPU_RDW) ? ram_rdata : '0;
  assign unused_jdo     = ^jdo;

`ifdef OCIMEM_AUTOINC_EN
  assign next_jtag_addr = jtag_addr + 1'b1;
`else
  assign next_jtag_addr = jtag_addr;
`endif

  // Tie history only moves on real contention, so the side that lost a tie wins the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ram_we        <= 1'b0;
      ram_re        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      jtag_addr     <= '0;
      pend          <= 1'b0;
      pend_wr       <= 1'b0;
      pend_wdata    <= '0;
      last_grant    <= START_GRANT;
    end else begin
      case (state)
        IDLE: begin
          if (tie) begin
            last_grant <= grant_jtag;
          end
          if (grant_jtag) begin
            pend      <= 1'b0;
            ram_addr  <= jtag_addr;
            ram_wdata <= pend_wdata;
            ram_we    <= pend_wr;
            ram_re    <= ~pend_wr;
            state     <= pend_wr ? J_WR : J_RD;
          end else if (grant_cpu) begin
            ram_addr  <= av_address;
            ram_wdata <= av_writedata;
            ram_we    <= av_write;
            ram_re    <= ~av_write;
            state     <= av_write ? CPU_WR : CPU_RD;
          end
        end
        CPU_WR: begin
          ram_we <= 1'b0;
          state  <= IDLE;
        end
        CPU_RD: begin
          ram_re <= 1'b0;
          state  <= CPU_RDW;
        end
        CPU_RDW: begin
          state <= IDLE;
        end
        J_WR: begin
          ram_we        <= 1'b0;
          MonDReg       <= ram_wdata;
          monitor_ready <= 1'b1;
          jtag_addr     <= next_jtag_addr;
          state         <= IDLE;
        end
        J_RD: begin
          ram_re <= 1'b0;
          state  <= J_RDW;
        end
        J_RDW: begin
          MonDReg       <= ram_rdata;
          monitor_ready <= 1'b1;
          jtag_addr     <= next_jtag_addr;
          state         <= IDLE;
        end
        default: begin
          ram_we <= 1'b0;
          ram_re <= 1'b0;
          state  <= IDLE;
        end
      endcase

      // Command decode; a busy engine drops the command and flags it until the next accepted 'a'.
      if (take_action_ocimem_b) begin
        if (jtag_busy) begin
          monitor_error <= 1'b1;
        end else begin
          pend          <= 1'b1;
          pend_wr       <= 1'b1;
          pend_wdata    <= jdo[34:3];
          monitor_ready <= 1'b0;
        end
      end else if (take_action_ocimem_a) begin
        if (jtag_busy) begin
          monitor_error <= 1'b1;
        end else begin
          jtag_addr     <= jdo[17 +: ADDR_W];
          monitor_error <= 1'b0;
          if (jdo[26]) begin
            pend          <= 1'b1;
            pend_wr       <= 1'b0;
            monitor_ready <= 1'b0;
          end else begin
            monitor_ready <= 1'b1;
          end
        end
      end else if (take_no_action_ocimem_a) begin
        if (jtag_busy) begin
          monitor_error <= 1'b1;
        end else begin
          pend          <= 1'b1;
          pend_wr       <= 1'b0;
          monitor_ready <= 1'b0;
        end
      end
    end
  end

endmodule
